// File: rtl/registers_pkg.sv
// Shared types and helpers for the register-space cycle terminator.
package registers_pkg;

  // Terminator sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    ACK   = 3'd2,
    ERR   = 3'd3,
    HOLD  = 3'd4
  } state_e;

  // Wait count of the fixed single-region terminator this block replaces.
  localparam int LEGACY_WAIT = 3;

  // Width of a region index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/registers_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module registers_prio_enc
  import registers_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/registers_term_multi.sv
// Multi-region cycle terminator: programmable wait per region, DSACK-style
// strobe, and bus-error timeout for DMAC_ cycles nobody claims.
module registers_term_multi
  import registers_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int CNT_W       = 3,
  parameter int TO_CYC      = 16
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            AS_,
  input  logic                            DMAC_,
  input  logic [NUM_REGIONS-1:0]          REQ,
  input  logic [NUM_REGIONS-1:0]          EN,
  input  logic [NUM_REGIONS*CNT_W-1:0]    WAIT_CFG,
  output logic                            REG_DSK_,
  output logic                            BERR_,
  output logic [idx_w(NUM_REGIONS)-1:0]   REGION,
  output logic                            DONE
);

  localparam int IDX_W = idx_w(NUM_REGIONS);
  localparam int TO_W  = 8;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [CNT_W-1:0]   w_q,      w_d;
  logic [IDX_W-1:0]   region_q, region_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               dsk_q,    dsk_d;
  logic               berr_q,   berr_d;
  logic               done_q,   done_d;

  logic               cyc;
  logic [NUM_REGIONS-1:0] claim;
  logic               claim_valid;
  logic [IDX_W-1:0]   claim_idx;
  logic [CNT_W-1:0]   claim_w;
  logic [CNT_W-1:0]   cnt_inc;

  assign cyc     = ~AS_ & ~DMAC_;
  assign claim   = REQ & EN;
  assign claim_w = WAIT_CFG[claim_idx*CNT_W +: CNT_W];
  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  registers_prio_enc #(
    .N  (NUM_REGIONS),
    .IW (IDX_W)
  ) u_prio (
    .req_i   (claim),
    .valid_o (claim_valid),
    .idx_o   (claim_idx)
  );

  // State register: synchronous reset wins over any cycle in progress.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_q      <= '0;
      region_q <= '0;
      to_cnt_q <= '0;
      dsk_q    <= 1'b1;
      berr_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      region_q <= region_d;
      to_cnt_q <= to_cnt_d;
      dsk_q    <= dsk_d;
      berr_q   <= berr_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: claim, wait, acknowledge, timeout and recovery.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    region_d = region_q;
    to_cnt_d = to_cnt_q;
    dsk_d    = dsk_q;
    berr_d   = berr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc && claim_valid) begin
          // A claim beats a running timeout on the same edge.
          region_d = claim_idx;
          w_d      = claim_w;
          cnt_d    = '0;
          to_cnt_d = '0;
          if (claim_w == '0) begin
            state_d = ACK;
            dsk_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end else if (cyc) begin
          if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
            state_d  = ERR;
            berr_d   = 1'b0;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end else begin
          to_cnt_d = '0;
        end
      end
      COUNT: begin
        // Latched wait and region are used; live WAIT_CFG/REQ are ignored here.
        if (!cyc) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == w_q) begin
            state_d = ACK;
            dsk_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ACK: begin
        // Only AS_ ends the acknowledge; DMAC_ dropping away does not.
        if (AS_) begin
          state_d = HOLD;
          dsk_d   = 1'b1;
        end
      end
      ERR: begin
        if (AS_) begin
          state_d = HOLD;
          berr_d  = 1'b1;
        end
      end
      HOLD: begin
        // One recovery cycle; no claim is taken here even with AS_ low.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: strobes release combinationally as soon as AS_ rises.
  always_comb begin
    REG_DSK_ = dsk_q | AS_;
    BERR_    = berr_q | AS_;
    REGION   = region_q;
    DONE     = done_q;
  end

endmodule

// File: doc/registers_term_multi.md
Name: registers_term_multi

Overview:
Parametrised cycle-termination generator for register-space accesses on the Amiga host bus. It supports NUM_REGIONS request sources, each with a runtime-programmable wait count, and generates the DSACK-style strobe REG_DSK_. It adds a bus-error timeout for DMAC_ cycles that no region claims. It sits between host address decode and the register file and replaces the fixed single-region, 3-wait terminator.

Parameters:
NUM_REGIONS, 2, number of independent register regions / request lines
CNT_W, 3, width of the wait counter and of each per-region wait field
TO_CYC, 16, cycles of unclaimed DMAC_ cycle before BERR_ asserts (must be < 2**8)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
AS_  in  1  address strobe, active low, already synchronised to CLK
DMAC_  in  1  chip select for this device, active low
REQ  in  NUM_REGIONS  per-region access request, active high (e.g. WD register request)
EN  in  NUM_REGIONS  per-region enable; a disabled region's REQ is ignored
WAIT_CFG  in  NUM_REGIONS*CNT_W  packed wait counts; region i uses bits [i*CNT_W +: CNT_W]
REG_DSK_  out  1  cycle termination strobe, active low
BERR_  out  1  bus error, active low
REGION  out  $clog2(NUM_REGIONS) (min 1)  index of the region terminating the current cycle
DONE  out  1  single-cycle pulse on the edge at which REG_DSK_ first asserts

Behaviour:
- Reset (RESET=1 at an edge): state IDLE, counters 0, REG_DSK_=1, BERR_=1, REGION=0, DONE=0. Reset overrides all other inputs, including a cycle in progress.
- cyc = ~AS_ & ~DMAC_. claim = REQ & EN. A region is selected by the lowest set index of claim (fixed priority).
- The REG_DSK_ output equals dsk_q | AS_. The strobe therefore releases combinationally when AS_ rises. BERR_ is gated the same way: berr_q | AS_.
- States: IDLE, COUNT, ACK, ERR, HOLD.
- IDLE:
  - If cyc and claim≠0: latch REGION and its wait value W, and set cnt=0.
    - W==0: go to ACK on this edge (dsk_q=0, DONE=1).
    - Otherwise go to COUNT.
  - If cyc and claim==0: increment to_cnt. When to_cnt reaches TO_CYC-1, go to ERR (berr_q=0).
  - If cyc is false, to_cnt=0.
- COUNT:
  - If cyc is lost, return to IDLE.
  - Otherwise cnt+=1. When cnt+1==W, go to ACK (dsk_q=0, DONE=1).
  - The latched W is used; WAIT_CFG changes mid-cycle have no effect. The latched REGION is held even if its REQ drops.
- ACK: dsk_q stays 0. DONE returns to 0 the next cycle. On AS_ high, go to HOLD with dsk_q=1.
- ERR: berr_q stays 0 until AS_ is high, then go to HOLD with berr_q=1.
- HOLD: one recovery cycle, then IDLE. A new cycle cannot be claimed in HOLD, even if AS_ is already low again.
- Counter: cnt is CNT_W bits and saturates at 2**CNT_W-1. It never wraps. W=2**CNT_W-1 is the maximum wait.
- Latency: REG_DSK_ falls at edge W+1 counted from the first edge with cyc and claim valid (W+1 edges total). W=3 matches the legacy terminator, which asserts at the 4th active edge.
- A claim appearing after the timeout count has started resets to_cnt and starts a normal cycle; claim wins over timeout on the same edge.
- DMAC_ going high while in ACK does not release REG_DSK_; only AS_ or RESET release it.
- REG_DSK_ and BERR_ are never both low.

Decomposition:
- Shared package registers_pkg:
  - state enum: IDLE, COUNT, ACK, ERR, HOLD
  - localparam for the legacy default wait (3)
  - function for the priority-encode width calc
- One natural sub-module: registers_prio_enc, a parametrised lowest-index priority encoder giving a valid flag and index.
- Everything else is flat.

Test Plan:
- NUM_REGIONS=2, WAIT_CFG={3'd5,3'd3}. AS_/DMAC_ low with REQ=01 → REG_DSK_ falls at the 4th edge, REGION=0, DONE pulses for 1 cycle. AS_ high → REG_DSK_ high in the same cycle (combinational).
- REQ=11 with EN=11 → region 0 wins with W=3. Then EN=10 with REQ=11 → region 1, REG_DSK_ at the 6th edge.
- W=0 → REG_DSK_ low on the 1st edge. W=7 → low on the 8th edge, no wrap.
- cyc with REQ=00 held for 16 edges → BERR_ low at edge 16, REG_DSK_ stays high. AS_ high → BERR_ high, one HOLD cycle, then IDLE.
- AS_ rises in COUNT at cnt=1 → IDLE, no DONE, no REG_DSK_. A WAIT_CFG change mid-COUNT does not alter the termination edge.
- RESET=1 during ACK with AS_ still low → next edge REG_DSK_=1, BERR_=1, DONE=0, state IDLE. After RESET drops with AS_ still low, a fresh claim restarts the count from 0.
